morse_decoder: RTL



---
 rtl/morse_decoder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes and debounces a key line, times marks/gaps and emits ASCII
// bytes over valid/ready. Define MORSE_DECODER_PUNCT_EN to decode . , ? / = as well.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES     = 5_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_BITS        = $clog2(8 * UNIT_CYCLES)
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       morse_i,
    input  logic       ready_i,
    output logic [7:0] ascii_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       overrun_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {StIdle, StMark, StGap, StWord} state_e;

    localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DebW-1:0]     DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TwoUnits  = CNT_BITS'(2 * UNIT_CYCLES);
    localparam logic [CNT_BITS-1:0] FiveUnits = CNT_BITS'(5 * UNIT_CYCLES);
    localparam logic [CNT_BITS-1:0] CntMax    = CNT_BITS'(8 * UNIT_CYCLES - 1);

    logic [1:0]          sync_q;
    logic                key_q, key_prev_q;
    logic [DebW-1:0]     deb_cnt_q;
    logic                rise, fall;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]          len_q, len_d;
    logic [5:0]          bits_q, bits_d;
    logic                ovf_q, ovf_d;

    logic                emit;
    logic [7:0]          emit_byte, dec_byte;
    logic                emit_err, dec_err;

    logic [7:0]          ascii_q;
    logic                valid_q, error_q, overrun_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q     <= '0;
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            sync_q     <= {sync_q[0], morse_i};
            key_prev_q <= key_q;
            if (sync_q[1] == key_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DebLast) begin
                key_q     <= sync_q[1];
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign rise    = key_q & ~key_prev_q;
    assign fall    = ~key_q & key_prev_q;
    // Saturate so an endless mark stays a dash instead of wrapping back to a dot.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        dec_byte = 8'h3F;
        dec_err  = 1'b0;
        if (ovf_q) begin
            dec_err = 1'b1;
        end else begin
            case ({len_q, bits_q})
                {3'd2, 6'b000001}: dec_byte = 8'h41;
                {3'd4, 6'b001000}: dec_byte = 8'h42;
                {3'd4, 6'b001010}: dec_byte = 8'h43;
                {3'd3, 6'b000100}: dec_byte = 8'h44;
                {3'd1, 6'b000000}: dec_byte = 8'h45;
                {3'd4, 6'b000010}: dec_byte = 8'h46;
                {3'd3, 6'b000110}: dec_byte = 8'h47;
                {3'd4, 6'b000000}: dec_byte = 8'h48;
                {3'd2, 6'b000000}: dec_byte = 8'h49;
                {3'd4, 6'b000111}: dec_byte = 8'h4A;
                {3'd3, 6'b000101}: dec_byte = 8'h4B;
                {3'd4, 6'b000100}: dec_byte = 8'h4C;
                {3'd2, 6'b000011}: dec_byte = 8'h4D;
                {3'd2, 6'b000010}: dec_byte = 8'h4E;
                {3'd3, 6'b000111}: dec_byte = 8'h4F;
                {3'd4, 6'b000110}: dec_byte = 8'h50;
                {3'd4, 6'b001101}: dec_byte = 8'h51;
                {3'd3, 6'b000010}: dec_byte = 8'h52;
                {3'd3, 6'b000000}: dec_byte = 8'h53;
                {3'd1, 6'b000001}: dec_byte = 8'h54;
                {3'd3, 6'b000001}: dec_byte = 8'h55;
                {3'd4, 6'b000001}: dec_byte = 8'h56;
                {3'd3, 6'b000011}: dec_byte = 8'h57;
                {3'd4, 6'b001001}: dec_byte = 8'h58;
                {3'd4, 6'b001011}: dec_byte = 8'h59;
                {3'd4, 6'b001100}: dec_byte = 8'h5A;
                {3'd5, 6'b011111}: dec_byte = 8'h30;
                {3'd5, 6'b001111}: dec_byte = 8'h31;
                {3'd5, 6'b000111}: dec_byte = 8'h32;
                {3'd5, 6'b000011}: dec_byte = 8'h33;
                {3'd5, 6'b000001}: dec_byte = 8'h34;
                {3'd5, 6'b000000}: dec_byte = 8'h35;
                {3'd5, 6'b010000}: dec_byte = 8'h36;
                {3'd5, 6'b011000}: dec_byte = 8'h37;
                {3'd5, 6'b011100}: dec_byte = 8'h38;
                {3'd5, 6'b011110}: dec_byte = 8'h39;
`ifdef MORSE_DECODER_PUNCT_EN
                {3'd6, 6'b010101}: dec_byte = 8'h2E;
                {3'd6, 6'b110011}: dec_byte = 8'h2C;
                {3'd6, 6'b001100}: dec_byte = 8'h3F;
                {3'd5, 6'b010010}: dec_byte = 8'h2F;
                {3'd5, 6'b010001}: dec_byte = 8'h3D;
`endif
                default:           dec_err  = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        len_d     = len_q;
        bits_d    = bits_q;
        ovf_d     = ovf_q;
        emit      = 1'b0;
        emit_byte = dec_byte;
        emit_err  = dec_err;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) state_d = StMark;
            end
            StMark: begin
                if (fall) begin
                    if (len_q == 3'd6) begin
                        ovf_d = 1'b1;
                    end else begin
                        bits_d = {bits_q[4:0], cnt_q >= TwoUnits};
                        len_d  = len_q + 3'd1;
                    end
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == TwoUnits) begin
                    emit    = 1'b1;
                    len_d   = '0;
                    bits_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = StWord;
                end
                if (rise) begin
                    cnt_d   = '0;
                    state_d = StMark;
                end
            end
            StWord: begin
                if (cnt_q == FiveUnits) begin
                    emit      = 1'b1;
                    emit_byte = 8'h20;
                    emit_err  = 1'b0;
                    state_d   = StIdle;
                end
                if (rise) begin
                    cnt_d   = '0;
                    state_d = StMark;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            bits_q    <= '0;
            ovf_q     <= 1'b0;
            ascii_q   <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
            ovf_q   <= ovf_d;
            // A byte arriving on the handshake cycle takes the slot being vacated.
            if (emit) begin
                if (!valid_q || ready_i) begin
                    ascii_q <= emit_byte;
                    error_q <= emit_err;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ascii_o   = ascii_q;
    assign valid_o   = valid_q;
    assign error_o   = error_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != StIdle);
endmodule
